// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination scoreboard with forwarding, stall, flush and multi-cycle hold
module hazard_scoreboard #(
    parameter int REG_AW = 4,
    parameter int NSRC   = 3,
    parameter int DEPTH  = 2,
    parameter int FWD_EN = 1,
    parameter int MC_W   = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_pc_en,
    input  logic                   i_id_vld,
    input  logic [NSRC*REG_AW-1:0] i_src_code,
    input  logic [NSRC-1:0]        i_src_vld,
    input  logic                   i_id_rd_vld,
    input  logic [REG_AW-1:0]      i_id_rd_code,
    input  logic                   i_id_rd_late,
    input  logic [MC_W-1:0]        i_id_mc_cyc,
    output logic                   o_id_flush,
    output logic                   o_ex_flush,
    output logic                   o_bubble,
    output logic [NSRC-1:0]        o_fwd_sel,
    output logic                   o_busy
);

    localparam logic [REG_AW-1:0] PC_CODE = '1;

    logic              vld_q  [DEPTH];
    logic              vld_d  [DEPTH];
    logic [REG_AW-1:0] code_q [DEPTH];
    logic [REG_AW-1:0] code_d [DEPTH];
    logic              late_q [DEPTH];
    logic              late_d [DEPTH];
    logic [MC_W-1:0]   cnt_q, cnt_d;

    logic              busy, hazard, pc_wr, issue;
    logic [NSRC-1:0]   fwd;

    assign busy  = (cnt_q != '0);
    assign pc_wr = vld_q[0] && (code_q[0] == PC_CODE);

    // Only the youngest matching stage decides forward versus stall for a port.
    always_comb begin : src_match
        logic found;
        hazard = 1'b0;
        fwd    = '0;
        found  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            found = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && i_src_vld[i] && vld_q[k] &&
                    (code_q[k] == i_src_code[i*REG_AW +: REG_AW])) begin
                    found = 1'b1;
                    if (k == 0 && FWD_EN != 0 && !late_q[0] && !busy) begin
                        fwd[i] = 1'b1;
                    end else begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

    assign o_bubble   = i_id_vld && (hazard || busy);
    assign o_id_flush = i_pc_en;
    assign o_ex_flush = i_pc_en || pc_wr || o_bubble;
    assign o_fwd_sel  = i_id_vld ? fwd : '0;
    assign o_busy     = busy;
    assign issue      = i_id_vld && !o_bubble && !i_pc_en && !pc_wr;

    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < DEPTH; k++) begin
            vld_d[k]  = vld_q[k];
            code_d[k] = code_q[k];
            late_d[k] = late_q[k];
        end
        if (i_pc_en || !busy) begin
            vld_d[0]  = issue && i_id_rd_vld;
            code_d[0] = issue ? i_id_rd_code : '0;
            late_d[0] = issue && i_id_rd_late;
            cnt_d     = issue ? i_id_mc_cyc : '0;
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k]  = vld_q[k-1];
                code_d[k] = code_q[k-1];
                late_d[k] = late_q[k-1];
            end
        end else begin
            // Multi-cycle hold: EX keeps its entry, stage 1 sees bubbles, older stages drain.
            cnt_d = cnt_q - MC_W'(1);
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k]  = (k == 1) ? 1'b0 : vld_q[k-1];
                code_d[k] = (k == 1) ? '0   : code_q[k-1];
                late_d[k] = (k == 1) ? 1'b0 : late_q[k-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                vld_q[k]  <= 1'b0;
                code_q[k] <= '0;
                late_q[k] <= 1'b0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int k = 0; k < DEPTH; k++) begin
                vld_q[k]  <= vld_d[k];
                code_q[k] <= code_d[k];
                late_q[k] <= late_d[k];
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed checks of hazard_scoreboard against a queue-based model
module tb_hazard_scoreboard;

    localparam int REG_AW = 4;
    localparam int NSRC   = 3;
    localparam int DEPTH  = 2;
    localparam int FWD_EN = 1;
    localparam int MC_W   = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   pc_en;
    logic                   id_vld;
    logic [NSRC*REG_AW-1:0] src_code;
    logic [NSRC-1:0]        src_vld;
    logic                   rd_vld;
    logic [REG_AW-1:0]      rd_code;
    logic                   rd_late;
    logic [MC_W-1:0]        mc_cyc;
    logic                   id_flush, ex_flush, bubble, busy;
    logic [NSRC-1:0]        fwd_sel;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit v;
        int code;
        bit late;
    } ent_t;

    ent_t m_st[$];
    int   m_cnt;
    bit   e_bubble, e_idfl, e_exfl, e_busy, e_pcw;
    bit [NSRC-1:0] e_fwd;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_AW(REG_AW), .NSRC(NSRC), .DEPTH(DEPTH), .FWD_EN(FWD_EN), .MC_W(MC_W)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_pc_en(pc_en),
        .i_id_vld(id_vld),
        .i_src_code(src_code),
        .i_src_vld(src_vld),
        .i_id_rd_vld(rd_vld),
        .i_id_rd_code(rd_code),
        .i_id_rd_late(rd_late),
        .i_id_mc_cyc(mc_cyc),
        .o_id_flush(id_flush),
        .o_ex_flush(ex_flush),
        .o_bubble(bubble),
        .o_fwd_sel(fwd_sel),
        .o_busy(busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ent_t inv = '{v: 0, code: 0, late: 0};
        m_st.delete();
        for (int k = 0; k < DEPTH; k++) m_st.push_back(inv);
        m_cnt = 0;
    endtask

    task automatic model_outputs();
        bit hz = 0;
        e_fwd = '0;
        for (int i = 0; i < NSRC; i++) begin
            int s = int'(src_code[i*REG_AW +: REG_AW]);
            if (src_vld[i]) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (m_st[k].v && m_st[k].code == s) begin
                        if (k == 0 && FWD_EN == 1 && !m_st[0].late && m_cnt == 0) e_fwd[i] = 1'b1;
                        else hz = 1;
                        break;
                    end
                end
            end
        end
        if (!id_vld) e_fwd = '0;
        e_busy   = (m_cnt > 0);
        e_bubble = id_vld && (hz || e_busy);
        e_pcw    = m_st[0].v && m_st[0].code == (1 << REG_AW) - 1;
        e_idfl   = pc_en;
        e_exfl   = pc_en || e_pcw || e_bubble;
    endtask

    task automatic model_advance();
        ent_t inv = '{v: 0, code: 0, late: 0};
        ent_t nw;
        bit   iss;
        if (pc_en) begin
            m_cnt = 0;
            m_st.push_front(inv);
            void'(m_st.pop_back());
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            m_st.insert(1, inv);
            void'(m_st.pop_back());
        end else begin
            iss = id_vld && !e_bubble && !e_pcw;
            nw  = iss ? '{v: rd_vld, code: int'(rd_code), late: rd_vld && rd_late} : inv;
            if (!rd_vld) nw = inv;
            m_st.push_front(nw);
            void'(m_st.pop_back());
            m_cnt = iss ? int'(mc_cyc) : 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        model_outputs();
        check_val({tag, ".fwd"},    fwd_sel,  e_fwd);
        check_val({tag, ".bubble"}, bubble,   e_bubble);
        check_val({tag, ".idfl"},   id_flush, e_idfl);
        check_val({tag, ".exfl"},   ex_flush, e_exfl);
        check_val({tag, ".busy"},   busy,     e_busy);
    endtask

    task automatic idle_inputs();
        pc_en = 0; id_vld = 0; src_code = '0; src_vld = '0;
        rd_vld = 0; rd_code = '0; rd_late = 0; mc_cyc = '0;
    endtask

    // Inputs change at the falling edge, outputs are checked 1ns later.
    task automatic drive(input bit idv, input bit [NSRC*REG_AW-1:0] sc, input bit [NSRC-1:0] sv,
                         input bit rv, input bit [REG_AW-1:0] rc, input bit rl,
                         input bit [MC_W-1:0] mc, input bit pc, input string tag);
        @(negedge clk);
        id_vld = idv; src_code = sc; src_vld = sv; rd_vld = rv;
        rd_code = rc; rd_late = rl; mc_cyc = mc; pc_en = pc;
        #1;
        check_outputs(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
    endtask

    task automatic issue(input bit [REG_AW-1:0] rd, input bit late, input bit [MC_W-1:0] mc, input string tag);
        drive(1, '0, '0, 1, rd, late, mc, 0, tag);
        tick();
    endtask

    task automatic nop(input string tag);
        drive(0, '0, '0, 0, '0, 0, '0, 0, tag);
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        #22;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1;

        issue(4'd3, 0, 0, "fwd_issue");
        drive(1, 12'h003, 3'b001, 0, '0, 0, '0, 0, "fwd_use");
        check_val("fwd_sel0_set", fwd_sel[0], 1'b1);
        check_val("fwd_no_bubble", bubble, 1'b0);
        tick();
        nop("fwd_drain");

        issue(4'd3, 1, 0, "late_issue");
        for (int c = 0; c < DEPTH; c++) begin
            drive(1, 12'h030, 3'b010, 0, '0, 0, '0, 0, "late_stall");
            check_val("late_bubble", bubble, 1'b1);
            check_val("late_exfl", ex_flush, 1'b1);
            tick();
        end
        drive(1, 12'h030, 3'b010, 0, '0, 0, '0, 0, "late_clear");
        check_val("late_bubble_done", bubble, 1'b0);
        tick();
        nop("late_drain");
        nop("late_drain2");

        issue(4'd5, 0, 2, "mc_issue");
        for (int c = 0; c < 2; c++) begin
            drive(1, '0, '0, 1, 4'd6, 0, '0, 0, "mc_busy");
            check_val("mc_busy_flag", busy, 1'b1);
            check_val("mc_bubble", bubble, 1'b1);
            tick();
        end
        drive(0, '0, '0, 0, '0, 0, '0, 0, "mc_done");
        check_val("mc_busy_clear", busy, 1'b0);
        tick();
        nop("mc_drain");
        nop("mc_drain2");

        issue(4'd5, 0, 3, "pc_issue");
        nop("pc_busy3");
        drive(1, '0, '0, 1, 4'd7, 0, '0, 1, "pc_flush");
        check_val("pc_idfl", id_flush, 1'b1);
        check_val("pc_exfl", ex_flush, 1'b1);
        tick();
        nop("pc_after");
        check_val("pc_busy_gone", busy, 1'b0);
        nop("pc_drain");

        issue(4'hF, 0, 0, "pcw_issue");
        drive(1, '0, '0, 1, 4'd2, 0, '0, 0, "pcw_flush");
        check_val("pcw_exfl", ex_flush, 1'b1);
        tick();
        nop("pcw_drain");
        nop("pcw_drain2");

        issue(4'd9, 0, 5, "rst_issue");
        drive(0, '0, '0, 0, '0, 0, '0, 0, "rst_busy");
        check_val("rst_busy_pre", busy, 1'b1);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_outputs("rst_async");
        check_val("rst_busy_async", busy, 1'b0);
        @(negedge clk);
        rst_n = 1;
        issue(4'd2, 0, 0, "post_rst_issue");
        drive(1, 12'h200, 3'b100, 0, '0, 0, '0, 0, "post_rst_fwd");
        check_val("post_rst_fwd2", fwd_sel[2], 1'b1);
        tick();

        for (int n = 0; n < 400; n++) begin
            bit [NSRC*REG_AW-1:0] sc;
            bit [REG_AW-1:0] rc;
            for (int i = 0; i < NSRC; i++) sc[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 5));
            rc = ($urandom_range(0, 19) == 0) ? 4'hF : REG_AW'($urandom_range(0, 5));
            drive($urandom_range(0, 3) != 0, sc, NSRC'($urandom),
                  $urandom_range(0, 4) != 0, rc, $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 4) == 0) ? MC_W'($urandom) : '0,
                  $urandom_range(0, 11) == 0, "rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter: REG_AW, default 4, register-code width.
REQ-002 Parameter: NSRC, default 3, number of source-operand ports.
REQ-003 Parameter: DEPTH, default 2, number of in-flight stages tracked after ID (stage 0 = EX); legal range 1..8.
REQ-004 Parameter: FWD_EN, default 1, enables EX-to-ID forwarding.
REQ-005 Parameter: MC_W, default 3, multi-cycle counter width.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-007 Port: i_clk, input, 1, rising-edge clock.
REQ-008 Port: i_rst_n, input, 1, asynchronous active-low reset.
REQ-009 Port: i_pc_en, input, 1, branch/PC write taken by the EX-stage instruction.
REQ-010 Port: i_id_vld, input, 1, valid instruction in ID.
REQ-011 Port: i_src_code, input, NSRC*REG_AW, source codes; port i occupies bits [i*REG_AW +: REG_AW].
REQ-012 Port: i_src_vld, input, NSRC, per-port source valid.
REQ-013 Port: i_id_rd_vld, input, 1, ID instruction writes a register.
REQ-014 Port: i_id_rd_code, input, REG_AW, ID destination code.
REQ-015 Port: i_id_rd_late, input, 1, result is ready only at the last stage (load); never forwardable.
REQ-016 Port: i_id_mc_cyc, input, MC_W, extra EX cycles; 0 means single-cycle.
REQ-017 Port: o_id_flush, output, 1, flush ID.
REQ-018 Port: o_ex_flush, output, 1, insert a bubble into EX.
REQ-019 Port: o_bubble, output, 1, stall IF/ID.
REQ-020 Port: o_fwd_sel, output, NSRC, per-port select for the EX result.
REQ-021 Port: o_busy, output, 1, multi-cycle operation in progress.

Function
REQ-022 The block SHALL hold DEPTH scoreboard entries {vld, code, late}, with stage k feeding stage k+1; the last stage retires.
REQ-023 Src match: port i SHALL match stage k if i_src_vld[i], entry k vld, and code equals port i's source code; only the lowest matching k counts.
REQ-024 Forward: a match at k=0 SHALL set o_fwd_sel[i]=1, with no stall, if FWD_EN=1, late=0, and the counter is 0.
REQ-025 Stall: any other match SHALL be a data hazard.
REQ-026 o_fwd_sel SHALL be 0 whenever i_id_vld=0.
REQ-027 PC write: a valid stage-0 entry with code all ones SHALL force o_ex_flush=1.
REQ-028 o_bubble SHALL equal i_id_vld && (data hazard || counter != 0).
REQ-029 o_id_flush SHALL equal i_pc_en.
REQ-030 o_ex_flush SHALL equal i_pc_en || stage-0 PC write || o_bubble.
REQ-031 Issue: on an edge with i_id_vld=1, o_bubble=0 and i_pc_en=0, stage 0 SHALL load {i_id_rd_vld, i_id_rd_code, i_id_rd_late} and the counter SHALL load i_id_mc_cyc.
REQ-032 Otherwise, with the counter at 0, stage 0 SHALL load an invalid entry.
REQ-033 Multi-cycle: while counter != 0, o_busy=1, stage 0 holds, stage 1 loads invalid, stages >=2 shift, and the counter decrements by 1 per cycle.
REQ-034 Normal shifting SHALL resume on the cycle after the counter reaches 0.
REQ-035 Counter decrement SHALL saturate at 0 with no wrap.
REQ-036 i_pc_en SHALL take priority over all other events.
REQ-037 On i_pc_en: the counter clears, stage 0 loads invalid, and stages >=1 shift normally, even when busy.
REQ-038 Issue and a stage-0 PC write in the same cycle SHALL be resolved by the flush, so no issue occurs.
REQ-039 With DEPTH=1, FWD_EN=0 and i_id_mc_cyc=0, all outputs except o_fwd_sel and o_busy SHALL match single-stage hazard-control behaviour.

Reset
REQ-040 When i_rst_n=0, all entries SHALL be invalid, code and late SHALL be 0, and the counter SHALL be 0, taking effect immediately regardless of clock.
REQ-041 After reset with idle inputs, every output SHALL be 0.
REQ-042 Reset asserted mid-multi-cycle SHALL abort the operation; o_busy=0 immediately.
REQ-043 The first edge after release SHALL behave as a normal issue.

Verification
REQ-044 Issue rd=3 (not late, mc=0); next cycle ID src0=3 valid -> o_fwd_sel[0]=1, o_bubble=0.
REQ-045 Issue rd=3 with late=1; next cycle src1=3 -> o_bubble=1 and o_ex_flush=1 for DEPTH cycles; then 0.
REQ-046 Issue with mc_cyc=2 -> o_busy=1 for 2 cycles and o_bubble=1 when i_id_vld=1; the stage-0 entry is retained; stage 1 receives 2 invalid entries.
REQ-047 i_pc_en=1 while the counter is 2 -> o_id_flush=1 and o_ex_flush=1; next cycle o_busy=0 and stage 0 is invalid.
REQ-048 Issue rd=4'hF -> next cycle o_ex_flush=1 with i_pc_en=0.
REQ-049 Assert i_rst_n=0 during mc_cyc=5 -> o_busy=0 and all outputs 0 without a clock edge.
